linha_retardo_prog: RTL and testbench

Programmable-length delay line: a W-bit bus (spike vector or neuron state) delayed by a runtime-selectable number of enabled clocks, 1..LMAX, held in a circular buffer. Generalisation of the fixed shift-register delay line used for axonal/synaptic delays in the Izhikevich network. Adds per-sample valid tracking, synchronous flush, live delay change without data loss, and illegal-delay flagging. Sits between a neuron-array output and the synapse/accumulator stage.

---
 rtl/linha_retardo_prog.sv | 114 +++++++++++
 tb/tb_linha_retardo_prog.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/linha_retardo_prog.sv
// rtl/linha_retardo_prog.sv - programmable-length delay line over a circular buffer
//
// Delays a W-bit bus by a runtime-selectable number of enabled clocks
// (1..LMAX). Each sample carries validity: O is only driven with data once
// enough history exists for the requested delay, otherwise O=0 and vld=0.
//
// Ports:
//   clk    clock, all state on rising edge
//   rst    asynchronous active-high reset
//   ena    advance strobe; the line moves only on edges where ena=1
//   flush  synchronous clear of the line (wins over ena)
//   dly    requested delay, legal 1..LMAX (0 acts as 1, >LMAX acts as LMAX)
//   A      input sample
//   O      delayed sample (registered, 0 when not valid)
//   vld    O holds a genuine delayed sample
//   err    dly was illegal on the last enabled edge
`timescale 1ns/1ps
module linha_retardo_prog #(
   parameter int W    = 32,
   parameter int LMAX = 16,
   parameter int DW   = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ena,
   input  logic          flush,
   input  logic [DW-1:0] dly,
   input  logic [W-1:0]  A,
   output logic [W-1:0]  O,
   output logic          vld,
   output logic          err
);

   localparam int AW = (LMAX > 1) ? $clog2(LMAX) : 1;
   // One extra bit so cnt+1 and wp+LMAX never overflow.
   localparam int CW = DW + 1;
   localparam logic [CW-1:0] LMAX_C  = CW'(LMAX);
   localparam logic [AW-1:0] WP_LAST = AW'(LMAX - 1);

   logic [W-1:0]  mem [LMAX];
   logic [AW-1:0] wp;
   logic [CW-1:0] cnt;

   logic          dly_zero;
   logic          dly_big;
   logic          dly_bad;
   logic [DW-1:0] deff;
   logic [CW-1:0] rd_sum;
   logic [AW-1:0] rd_idx;
   logic [W-1:0]  sel;
   logic          vld_new;
   logic          adv;

   assign adv = ena & ~flush;

   always_comb begin
      dly_zero = (dly == '0);
      dly_big  = (CW'(dly) > LMAX_C);
      dly_bad  = dly_zero | dly_big;
      if (dly_zero)
         deff = DW'(1);
      else if (dly_big)
         deff = DW'(LMAX);
      else
         deff = dly;

      // Read index = (wp - (deff-1)) mod LMAX. Adding LMAX first keeps the
      // sum positive, so a single conditional subtract finishes the modulo
      // without requiring LMAX to be a power of two.
      rd_sum = CW'(wp) + LMAX_C - (CW'(deff) - CW'(1));
      if (rd_sum >= LMAX_C)
         rd_idx = AW'(rd_sum - LMAX_C);
      else
         rd_idx = AW'(rd_sum);

      // Delay of one bypasses the buffer: the sample is the one being written.
      if (deff == DW'(1))
         sel = A;
      else
         sel = mem[rd_idx];

      // History available this edge includes the sample being written.
      vld_new = ((cnt + CW'(1)) >= CW'(deff));
   end

   // Buffer contents are never reset; cnt gating keeps stale entries off O.
   always_ff @(posedge clk) begin
      if (adv)
         mem[wp] <= A;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp  <= '0;
         cnt <= '0;
         O   <= '0;
         vld <= 1'b0;
         err <= 1'b0;
      end else if (flush) begin
         wp  <= '0;
         cnt <= '0;
         O   <= '0;
         vld <= 1'b0;
         err <= 1'b0;
      end else if (ena) begin
         wp  <= (wp == WP_LAST) ? '0 : wp + AW'(1);
         cnt <= (cnt == LMAX_C) ? cnt : cnt + CW'(1);
         O   <= vld_new ? sel : '0;
         vld <= vld_new;
         err <= dly_bad;
      end
   end

endmodule

// File: tb/tb_linha_retardo_prog.sv
// tb/tb_linha_retardo_prog.sv - self-checking bench for linha_retardo_prog
`timescale 1ns/1ps
module tb_linha_retardo_prog;

   localparam int W    = 32;
   localparam int LMAX = 16;
   localparam int DW   = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          ena;
   logic          flush;
   logic [DW-1:0] dly;
   logic [W-1:0]  A;
   logic [W-1:0]  O;
   logic          vld;
   logic          err;

   int checks = 0;
   int errors = 0;

   linha_retardo_prog #(.W(W), .LMAX(LMAX), .DW(DW)) dut (
      .clk   (clk),
      .rst   (rst),
      .ena   (ena),
      .flush (flush),
      .dly   (dly),
      .A     (A),
      .O     (O),
      .vld   (vld),
      .err   (err)
   );

   always #5 clk = ~clk;

   // Reference model: the history since the last flush as a queue of
   // enabled-edge samples; the output is the sample Deff-1 edges older than
   // the newest one, if that many exist.
   logic [W-1:0] hist [$];
   logic [W-1:0] m_o;
   logic         m_v;
   logic         m_e;

   task automatic model_clear();
      hist.delete();
      m_o = '0;
      m_v = 1'b0;
      m_e = 1'b0;
   endtask

   task automatic model_edge(input logic en, input logic fl, input int d, input logic [W-1:0] a);
      int de;
      if (fl) begin
         model_clear();
      end else if (en) begin
         de = (d == 0) ? 1 : (d > LMAX) ? LMAX : d;
         hist.push_back(a);
         if (hist.size() > LMAX) void'(hist.pop_front());
         m_v = (hist.size() >= de);
         m_o = m_v ? hist[hist.size() - de] : '0;
         m_e = (d == 0) || (d > LMAX);
      end
   endtask

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".O"},   O,          m_o);
      chk({tag, ".vld"}, W'(vld),    W'(m_v));
      chk({tag, ".err"}, W'(err),    W'(m_e));
   endtask

   // One clock: drive inputs, take the edge, update model, sample 1ns later.
   task automatic step(input logic en, input logic fl, input int d, input logic [W-1:0] a);
      ena   = en;
      flush = fl;
      dly   = DW'(d);
      A     = a;
      @(posedge clk);
      model_edge(en, fl, d, a);
      #1;
   endtask

   typedef struct {
      logic         en;
      logic         fl;
      int           d;
      logic [W-1:0] a;
      logic [W-1:0] o;
      logic         v;
      logic         e;
   } vec_t;

   vec_t tv [$];

   function automatic vec_t mk(input logic en, input logic fl, input int d, input logic [W-1:0] a,
                               input logic [W-1:0] o, input logic v, input logic e);
      vec_t r;
      r.en = en; r.fl = fl; r.d = d; r.a = a; r.o = o; r.v = v; r.e = e;
      return r;
   endfunction

   initial begin
      int vcnt;
      int cur_d;

      // dly=3 from reset, A=1,2,3...: first valid sample on edge 3 is A=1.
      for (int i = 1; i <= 8; i++)
         tv.push_back(mk(1'b1, 1'b0, 3, W'(i), (i >= 3) ? W'(i - 2) : '0, i >= 3, 1'b0));
      // Flush, then dly=2 with ena toggling.
      tv.push_back(mk(1'b1, 1'b1, 2, 99, 0,  1'b0, 1'b0));
      tv.push_back(mk(1'b1, 1'b0, 2, 10, 0,  1'b0, 1'b0));
      tv.push_back(mk(1'b0, 1'b0, 2, 11, 0,  1'b0, 1'b0));
      tv.push_back(mk(1'b1, 1'b0, 2, 12, 10, 1'b1, 1'b0));
      tv.push_back(mk(1'b0, 1'b0, 2, 13, 10, 1'b1, 1'b0));
      tv.push_back(mk(1'b1, 1'b0, 2, 14, 12, 1'b1, 1'b0));
      tv.push_back(mk(1'b0, 1'b0, 2, 15, 12, 1'b1, 1'b0));
      tv.push_back(mk(1'b1, 1'b0, 2, 16, 14, 1'b1, 1'b0));
      // Illegal delays: 0 acts as 1, 20 acts as 16; err clears on legal dly.
      tv.push_back(mk(1'b1, 1'b0, 0,  20, 20, 1'b1, 1'b1));
      tv.push_back(mk(1'b1, 1'b0, 20, 21, 0,  1'b0, 1'b1));
      tv.push_back(mk(1'b0, 1'b0, 3,  22, 0,  1'b0, 1'b1));
      tv.push_back(mk(1'b1, 1'b0, 3,  23, 20, 1'b1, 1'b0));

      rst = 1'b1; ena = 1'b0; flush = 1'b0; dly = '0; A = '0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      chk("reset.O", O, '0);
      chk("reset.vld", W'(vld), '0);
      chk("reset.err", W'(err), '0);
      rst = 1'b0;

      foreach (tv[i]) begin
         step(tv[i].en, tv[i].fl, tv[i].d, tv[i].a);
         chk($sformatf("tv%0d.O", i),   O,       tv[i].o);
         chk($sformatf("tv%0d.vld", i), W'(vld), W'(tv[i].v));
         chk($sformatf("tv%0d.err", i), W'(err), W'(tv[i].e));
      end

      // dly=LMAX over 40 clocks: two pointer wraps, O=n-15 from edge 16.
      step(1'b0, 1'b1, 16, 0);
      for (int n = 1; n <= 40; n++) begin
         step(1'b1, 1'b0, 16, W'(n));
         chk($sformatf("full%0d.vld", n), W'(vld), W'(n >= 16));
         chk($sformatf("full%0d.O", n), O, (n >= 16) ? W'(n - 15) : '0);
      end

      // Delay changes on a saturated line.
      for (int n = 41; n <= 50; n++) begin step(1'b1, 1'b0, 8, W'(n)); chk_model("d8"); end
      step(1'b1, 1'b0, 3, 51);
      chk("d3.O", O, 49);
      chk("d3.vld", W'(vld), 1);
      step(1'b1, 1'b0, 12, 52);
      chk("d12.O", O, 41);
      chk("d12.vld", W'(vld), 1);

      // After flush, dly=12 needs 11 edges of history before vld.
      step(1'b1, 1'b1, 12, 53);
      vcnt = 0;
      for (int n = 0; n < 11; n++) begin
         step(1'b1, 1'b0, 12, W'(100 + n));
         if (!vld) vcnt++;
      end
      chk("flush12.novld", W'(vcnt), 11);
      step(1'b1, 1'b0, 12, 111);
      chk("flush12.O", O, 100);

      // Mid-stream flush with ena: A discarded, O/vld cleared next edge.
      step(1'b1, 1'b0, 1, 200);
      step(1'b1, 1'b1, 1, 201);
      chk_model("midflush");
      chk("midflush.vld", W'(vld), 0);
      step(1'b1, 1'b0, 2, 202);
      chk_model("postflush");

      // Async reset between edges.
      step(1'b1, 1'b0, 0, 300);
      #2 rst = 1'b1;
      #1;
      chk("arst.O", O, '0);
      chk("arst.vld", W'(vld), '0);
      chk("arst.err", W'(err), '0);
      model_clear();
      @(negedge clk);
      rst = 1'b0;

      // Randomized stream against the model.
      cur_d = 5;
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 15) == 0) cur_d = $urandom_range(0, 20);
         step($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, cur_d, $urandom);
         chk_model($sformatf("rnd%0d", n));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
